// File: rtl/bit_index_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_index_scanner_pkg
//  Description : Shared types and defaults for the bit index scanner.
//                Scan direction follows macro SCANNER_MSB_FIRST_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package bit_index_scanner_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_idx_w = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

`ifdef SCANNER_MSB_FIRST_EN
    localparam bit c_msb_first = 1'b1;
`else
    localparam bit c_msb_first = 1'b0;
`endif

endpackage : bit_index_scanner_pkg
`default_nettype wire

// File: rtl/bit_index_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_index_scanner_if
//  Description : Word-in / index-out handshake bundle for bit_index_scanner.
//  Revision    : 1.0  initial release
// ============================================================================
interface bit_index_scanner_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             zero_word;
    logic             busy;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out_idx, out_last, zero_word, busy
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out_idx, out_last, zero_word, busy
    );
endinterface : bit_index_scanner_if
`default_nettype wire

// File: rtl/bit_index_scanner_priority_encoder16.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder16
//  Description : Selects the lowest set bit (highest when SCANNER_MSB_FIRST_EN
//                is defined) and returns its index plus a one-hot clear mask.
//  Revision    : 1.0  initial release
// ============================================================================
module priority_encoder16
    import bit_index_scanner_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int IDX_W = c_default_idx_w
) (
    input  wire logic [WIDTH-1:0] in,
    output logic      [IDX_W-1:0] idx,
    output logic      [WIDTH-1:0] onehot_clear
);

    // Walk from the lowest-priority end so the last hit is the winner.
    always_comb begin
        idx          = '0;
        onehot_clear = '0;
        for (int i = 0; i < WIDTH; i++) begin
            int j;
            j = c_msb_first ? i : (WIDTH - 1 - i);
            if (in[j]) begin
                idx             = IDX_W'(j);
                onehot_clear    = '0;
                onehot_clear[j] = 1'b1;
            end
        end
    end

endmodule : priority_encoder16
`default_nettype wire

// File: rtl/bit_index_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bit_index_scanner
//  Description : Accepts a word and emits the index of each set bit, one per
//                cycle, lowest-first (highest-first with SCANNER_MSB_FIRST_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module bit_index_scanner
    import bit_index_scanner_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int IDX_W = c_default_idx_w
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bit_index_scanner_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             r_zero_word;
    logic             w_zero_nxt;

    logic [IDX_W-1:0] w_enc_idx;
    logic [WIDTH-1:0] w_enc_onehot;
    logic             w_single;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    priority_encoder16 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_penc (
        .in           (r_pending),
        .idx          (w_enc_idx),
        .onehot_clear (w_enc_onehot)
    );

    // Clearing the lowest set bit leaves zero only when one bit remains.
    assign w_single = ((r_pending & (r_pending - WIDTH'(1))) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_zero_word <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_zero_word <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_zero_nxt    = 1'b0;
        w_in_ready    = 1'b0;
        w_out_valid   = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in != '0) begin
                        w_pending_nxt = bus.in;
                        w_state_nxt   = ST_EMIT;
                    end else begin
                        w_zero_nxt = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
                if (bus.out_ready) begin
                    w_pending_nxt = r_pending & ~w_enc_onehot;
                    if (w_single) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = w_out_valid ? w_enc_idx : '0;
    assign bus.out_last  = w_out_valid & w_single;
    assign bus.zero_word = r_zero_word;
    assign bus.busy      = w_busy;

endmodule : bit_index_scanner
`default_nettype wire

// File: tb/tb_bit_index_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_index_scanner
//  Description : Self-checking bench for bit_index_scanner with an expected-beat queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_index_scanner;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    bit_index_scanner_if #(.WIDTH(16), .IDX_W(4)) bus ();

    bit_index_scanner #(.WIDTH(16), .IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat order derived independently from the word value.
    task automatic push_word(input logic [15:0] w);
        int cnt;
        int seen;
        cnt  = $countones(w);
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            int b;
`ifdef SCANNER_MSB_FIRST_EN
            b = 15 - k;
`else
            b = k;
`endif
            if (w[b]) begin
                exp_t e;
                seen++;
                e.idx  = 4'(b);
                e.last = (seen == cnt);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in       = w;
        tick();
        bus.in_valid = 1'b0;
        push_word(w);
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_idx !== 4'd0 ||
            bus.out_last !== 1'b0 || bus.zero_word !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: rdy=%b vld=%b idx=%0d last=%b zw=%b busy=%b required 1 0 0 0 0 0",
                     name, bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last,
                     bus.zero_word, bus.busy);
        end
    endtask

    // Pops and compares every handshake; strict mode also demands no gaps.
    task automatic collect(input int budget, input bit strict, output int busy_cycles);
        int cyc;
        cyc         = 0;
        busy_cycles = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                if (bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                    n_err++;
                    $display("FAIL beat: idx=%0d last=%b required idx=%0d last=%b",
                             bus.out_idx, bus.out_last, e.idx, e.last);
                end
            end else if (strict) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_gap: out_valid=%b required 1", bus.out_valid);
            end
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL collect_timeout: %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int bc;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in       = 16'h0003;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("reset_values");
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drop_word: out_valid=%b required 0", bus.out_valid);
        end
        bc = 0;
    endtask

    task automatic test_sparse();
        int bc;
        bus.out_ready = 1'b1;
        send_word(16'h8421);
        collect(20, 1'b1, bc);
        check_idle("sparse_after");
    endtask

    task automatic test_zero();
        send_word(16'h0000);
        n_vec++;
        if (bus.zero_word !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL zero_pulse: zw=%b vld=%b rdy=%b required 1 0 1",
                     bus.zero_word, bus.out_valid, bus.in_ready);
        end
        tick();
        check_idle("zero_after");
    endtask

    task automatic test_stall();
        int bc;
        bus.out_ready = 1'b0;
        send_word(16'h0006);
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(exp_q[0].idx) ||
                bus.out_last !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: vld=%b idx=%0d last=%b required 1 %0d 0",
                         bus.out_valid, bus.out_idx, bus.out_last, exp_q[0].idx);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        collect(10, 1'b1, bc);
        check_idle("stall_after");
    endtask

    task automatic test_full();
        int bc;
        bus.out_ready = 1'b1;
        send_word(16'hFFFF);
        bus.in_valid = 1'b1;
        bus.in       = 16'h0001;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_in_ready: in_ready=%b required 0", bus.in_ready);
        end
        collect(40, 1'b1, bc);
        bus.in_valid = 1'b0;
        n_vec++;
        if (bc != 16) begin
            n_err++;
            $display("FAIL full_busy_cycles: %0d required 16", bc);
        end
        check_idle("full_after");
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_ignored_word: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int bc;
        bus.out_ready = 1'b1;
        send_word(16'h00F0);
        for (int s = 0; s < 2; s++) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                n_err++;
                $display("FAIL pre_reset_beat: vld=%b idx=%0d last=%b required 1 %0d %b",
                         bus.out_valid, bus.out_idx, bus.out_last, e.idx, e.last);
            end
            if (s == 1) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        exp_q.delete();
        check_idle("mid_reset");
        tick();
        check_idle("mid_reset_quiet");
        send_word(16'h0001);
        collect(10, 1'b1, bc);
        check_idle("post_reset_word");
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sparse();
        test_zero();
        test_stall();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_bit_index_scanner
`default_nettype wire
